dd_bcd_conv: RTL and testbench

- Iterative bidirectional binary/BCD converter with valid/ready handshake on input and output.
- Binary-to-BCD uses double dabble: shift left, add 3 to digits >4. BCD-to-binary uses reverse double dabble: shift right, subtract 3 from digits >7.
- DEP bit-steps are cascaded per clock.
- Sits beside the decimal float units as the shared radix converter for format conversion and display paths.

---
 rtl/dd_bcd_conv.sv | 191 +++++++++++++++++++
 tb/tb_dd_bcd_conv.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dd_bcd_conv.sv
// Iterative binary<->BCD converter (double dabble / reverse double dabble).
// DDBCD_SIGNED_EN enables two's-complement binary and signed BCD.
module dd_bcd_conv #(
  parameter int WID = 64,
  parameter int DEP = 2,
  localparam int BCDWID = ((WID + (WID - 4) / 3) + 3) & ~3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WID-1:0]    bin_i,
  input  logic [BCDWID-1:0] bcd_i,
  input  logic              sign_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WID-1:0]    bin_o,
  output logic [BCDWID-1:0] bcd_o,
  output logic              sign_o,
  output logic              ovf_o,
  output logic              err_o
);

  localparam int STEPS = WID / DEP;
  localparam int CW = $clog2(STEPS + 1);
  localparam int NDIG = BCDWID / 4;

  if (WID % DEP != 0 || DEP < 1 || DEP > WID) begin : g_bad_cfg
    $error("dd_bcd_conv: WID must be divisible by DEP, DEP in 1..WID");
  end

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BCDWID-1:0] wbcd_q, wbcd_d, bcd_c;
  logic [WID-1:0] wbin_q, wbin_d, bin_c;
  logic mode_q, mode_d;
  logic err_q, err_d;
  logic sign_q, sign_d;
  logic [BCDWID-1:0] rbcd_q, rbcd_d;
  logic [WID-1:0] rbin_q, rbin_d;
  logic rsign_q, rsign_d;
  logic rovf_q, rovf_d;
  logic rerr_q, rerr_d;
  logic bad_c;
  logic [WID-1:0] mag_c;
  logic sgn_c;
  logic [WID-1:0] fbin_c;
  logic fovf_c;

  // DEP cascaded steps; digit correction is per nibble, no inter-digit carry
  always_comb begin
    bcd_c = wbcd_q;
    bin_c = wbin_q;
    for (int s = 0; s < DEP; s++) begin
      if (!mode_q) begin
        for (int d = 0; d < NDIG; d++)
          if (bcd_c[4*d+:4] > 4'd4)
            bcd_c[4*d+:4] = bcd_c[4*d+:4] + 4'd3;
        {bcd_c, bin_c} = {bcd_c, bin_c} << 1;
      end else begin
        {bcd_c, bin_c} = {bcd_c, bin_c} >> 1;
        for (int d = 0; d < NDIG; d++)
          if (bcd_c[4*d+:4] > 4'd7)
            bcd_c[4*d+:4] = bcd_c[4*d+:4] - 4'd3;
      end
    end
  end

  always_comb begin
    bad_c = 1'b0;
    for (int d = 0; d < NDIG; d++)
      if (bcd_i[4*d+:4] > 4'd9) bad_c = 1'b1;
  end

`ifdef DDBCD_SIGNED_EN
  always_comb begin
    mag_c = (!mode && bin_i[WID-1]) ? -bin_i : bin_i;
    sgn_c = mode ? sign_i : bin_i[WID-1];
    fbin_c = sign_q ? -bin_c : bin_c;
    fovf_c = (|bcd_c) | (sign_q ? (bin_c[WID-1] & (|bin_c[WID-2:0]))
                                : bin_c[WID-1]);
  end
`else
  logic unused_sign;
  assign unused_sign = sign_i;
  always_comb begin
    mag_c = bin_i;
    sgn_c = 1'b0;
    fbin_c = bin_c;
    fovf_c = |bcd_c;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wbcd_d = wbcd_q;
    wbin_d = wbin_q;
    mode_d = mode_q;
    err_d = err_q;
    sign_d = sign_q;
    rbcd_d = rbcd_q;
    rbin_d = rbin_q;
    rsign_d = rsign_q;
    rovf_d = rovf_q;
    rerr_d = rerr_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = RUN;
            cnt_d = CW'(STEPS);
            mode_d = mode;
            wbin_d = mode ? '0 : mag_c;
            wbcd_d = mode ? bcd_i : '0;
            err_d = mode & bad_c;
            sign_d = sgn_c;
          end
        end
        RUN: begin
          wbcd_d = bcd_c;
          wbin_d = bin_c;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = HOLD;
            rsign_d = sign_q;
            rerr_d = err_q;
            if (!mode_q) begin
              rbcd_d = bcd_c;
              rbin_d = '0;
              rovf_d = 1'b0;
            end else begin
              rbcd_d = '0;
              rbin_d = fbin_c;
              rovf_d = fovf_c;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wbcd_q <= '0;
      wbin_q <= '0;
      mode_q <= 1'b0;
      err_q <= 1'b0;
      sign_q <= 1'b0;
      rbcd_q <= '0;
      rbin_q <= '0;
      rsign_q <= 1'b0;
      rovf_q <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wbcd_q <= wbcd_d;
      wbin_q <= wbin_d;
      mode_q <= mode_d;
      err_q <= err_d;
      sign_q <= sign_d;
      rbcd_q <= rbcd_d;
      rbin_q <= rbin_d;
      rsign_q <= rsign_d;
      rovf_q <= rovf_d;
      rerr_q <= rerr_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign bin_o = rbin_q;
  assign bcd_o = rbcd_q;
  assign sign_o = rsign_q;
  assign ovf_o = rovf_q;
  assign err_o = rerr_q;

endmodule

// File: tb/tb_dd_bcd_conv.sv
// Randomized bench for dd_bcd_conv (WID=16, DEP=2) against a decimal
// arithmetic reference model; honours DDBCD_SIGNED_EN.
module tb_dd_bcd_conv;

  localparam int WID = 16;
  localparam int DEP = 2;
  localparam int BW = 20;
  localparam int LAT = WID / DEP;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic mode;
  logic in_valid;
  logic in_ready;
  logic [WID-1:0] bin_i;
  logic [BW-1:0] bcd_i;
  logic sign_i;
  logic out_valid;
  logic out_ready;
  logic [WID-1:0] bin_o;
  logic [BW-1:0] bcd_o;
  logic sign_o;
  logic ovf_o;
  logic err_o;

  int checks = 0;
  int errors = 0;

  dd_bcd_conv #(.WID(WID), .DEP(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .bin_i(bin_i), .bcd_i(bcd_i), .sign_i(sign_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .bin_o(bin_o), .bcd_o(bcd_o), .sign_o(sign_o),
    .ovf_o(ovf_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input longint v);
    logic [19:0] r;
    longint x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model(input logic m, input logic [15:0] b,
                       input logic [19:0] d, input logic s,
                       output logic [15:0] eb, output logic [19:0] ed,
                       output logic es, output logic eo,
                       output logic ee);
    longint val, mag, p;
    logic [3:0] dig;
    eb = '0; ed = '0; es = 1'b0; eo = 1'b0; ee = 1'b0;
    if (!m) begin
      mag = longint'(b);
`ifdef DDBCD_SIGNED_EN
      es = b[15];
      if (b[15]) mag = 65536 - mag;
`endif
      ed = to_bcd(mag);
    end else begin
      val = 0;
      p = 1;
      for (int i = 0; i < 5; i++) begin
        dig = d[i*4+:4];
        if (dig > 9) ee = 1'b1;
        val += longint'(dig) * p;
        p *= 10;
      end
`ifdef DDBCD_SIGNED_EN
      es = s;
      eo = s ? (val > 32768) : (val > 32767);
      eb = s ? 16'((65536 - val % 65536) % 65536) : 16'(val % 65536);
`else
      eo = val > 65535;
      eb = 16'(val % 65536);
`endif
    end
  endtask

  task automatic run_job(input logic m, input logic [15:0] b,
                         input logic [19:0] d, input logic s,
                         input int stall);
    logic [15:0] eb;
    logic [19:0] ed;
    logic es, eo, ee;
    int n;
    model(m, b, d, s, eb, ed, es, eo, ee);
    @(negedge clk);
    chk("acc_rdy", 64'(in_ready), 64'd1);
    mode = m; bin_i = b; bcd_i = d; sign_i = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode = ~m;
    bin_i = 16'($urandom);
    bcd_i = 20'($urandom);
    sign_i = ~s;
    n = 0;
    while (!out_valid && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(LAT));
    chk("sign", 64'(sign_o), 64'(es));
    if (!m) begin
      chk("bcd", 64'(bcd_o), 64'(ed));
      chk("bin0", 64'(bin_o), 64'd0);
      chk("ovf0", 64'(ovf_o), 64'd0);
      chk("err0", 64'(err_o), 64'd0);
    end else begin
      chk("err", 64'(err_o), 64'(ee));
      if (!ee) begin
        chk("bin", 64'(bin_o), 64'(eb));
        chk("ovf", 64'(ovf_o), 64'(eo));
      end
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("hold_v", 64'(out_valid), 64'd1);
      chk("hold_rdy", 64'(in_ready), 64'd0);
      if (!m) chk("hold_bcd", 64'(bcd_o), 64'(ed));
      else chk("hold_err", 64'(err_o), 64'(ee));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("done_v", 64'(out_valid), 64'd0);
    chk("done_rdy", 64'(in_ready), 64'd1);
  endtask

  logic [19:0] rd;
  logic [3:0] dg;

  initial begin
    rst_n = 1'b0; clr = 1'b0; mode = 1'b0; in_valid = 1'b0;
    bin_i = '0; bcd_i = '0; sign_i = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_v", 64'(out_valid), 64'd0);
    chk("rst_bcd", 64'(bcd_o), 64'd0);
    chk("rst_bin", 64'(bin_o), 64'd0);
    chk("rst_flags", 64'({sign_o, ovf_o, err_o}), 64'd0);
    #9;
    rst_n = 1'b1;

    run_job(1'b0, 16'hFFFF, 20'h0, 1'b0, 0);
    run_job(1'b1, 16'h0, 20'h65535, 1'b0, 1);
    run_job(1'b1, 16'h0, 20'h99999, 1'b0, 0);
    run_job(1'b1, 16'h0, 20'h0001A, 1'b0, 5);
    run_job(1'b0, 16'h8000, 20'h0, 1'b0, 0);
    run_job(1'b0, 16'h0000, 20'h0, 1'b0, 0);
    run_job(1'b1, 16'h0, 20'h32768, 1'b1, 0);
    run_job(1'b1, 16'h0, 20'h32768, 1'b0, 0);
    run_job(1'b1, 16'h0, 20'h32767, 1'b0, 0);
    run_job(1'b1, 16'h0, 20'h00000, 1'b1, 0);
    run_job(1'b1, 16'h0, 20'h65536, 1'b0, 0);

    // abort mid-job, with a competing request on the abort cycle
    @(negedge clk);
    mode = 1'b0; bin_i = 16'd1234; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_v", 64'(out_valid), 64'd0);
    chk("clr_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("clr_noacc_rdy", 64'(in_ready), 64'd1);
    chk("clr_noacc_v", 64'(out_valid), 64'd0);

    // asynchronous reset mid-job
    @(negedge clk);
    mode = 1'b0; bin_i = 16'd999; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_v", 64'(out_valid), 64'd0);
    chk("arst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(1'b0, 16'd1234, 20'h0, 1'b0, 2);

    for (int j = 0; j < 2000; j++) begin
      rd = '0;
      for (int i = 0; i < 5; i++) begin
        dg = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                           : 4'($urandom_range(0, 9));
        rd[i*4+:4] = dg;
      end
      run_job(1'(j % 2), 16'($urandom), rd, 1'($urandom),
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
